// File: rtl/facto_core_q.sv
// facto_core_q: bus-mapped factorial engine with an operand queue and a
// result queue. Each queued n is turned into n! mod 2^RES_W, using one
// multiply per cycle. A per-result overflow flag goes with each result, and
// a maskable level interrupt is raised when the batch drains.
//
// Bus semantics: there is no valid/ready pair. A write is taken at the clk
// edge where s_sel & s_wr is high; every write completes in that cycle.
// A read is combinational: while s_sel & !s_wr is high, s_dout shows the
// addressed register. Unmapped offsets read 0 and ignore writes.
module facto_core_q #(
    parameter logic [15:0] BASE_ADDR = 16'h7000,
    parameter int          OPW       = 8,
    parameter int          RES_W     = 64,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [15:0] s_addr,
    input  logic [63:0] s_din,
    output logic [63:0] s_dout,
    output logic        interrupt,
    output logic [1:0]  o_dbg_state
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         PRODW   = RES_W + OPW;
    localparam logic [7:0] DEPTH_C = 8'(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_MUL = 2'd2, S_STORE = 2'd3} state_t;

    state_t              r_state, w_state_nxt;
    logic [OPW-1:0]      r_op_mem  [DEPTH];
    logic [RES_W:0]      r_res_mem [DEPTH];
    logic [PW-1:0]       r_op_wptr, r_op_rptr, r_res_wptr, r_res_rptr;
    logic [7:0]          r_op_cnt, r_res_cnt;
    logic [RES_W-1:0]    r_acc;
    logic [OPW-1:0]      r_k;
    logic                r_f, r_run, r_done, r_ovf, r_err, r_inten, r_irq;

    logic                w_hit, w_wr, w_rd;
    logic [7:0]          w_off;
    logic                w_start_ok, w_clear, w_inten_wr, w_op_wr, w_pop_wr;
    logic                w_op_empty, w_op_full, w_res_empty, w_res_full;
    logic                w_op_push, w_op_pop, w_res_push, w_res_pop, w_busy;
    logic [PRODW-1:0]    w_prod;
    logic [RES_W-1:0]    w_head_res;
    logic                w_head_flag;
    logic                w_unused_din;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Address decode and register strobes.
    assign w_hit        = s_sel && (s_addr[15:8] == BASE_ADDR[15:8]);
    assign w_wr         = w_hit && s_wr;
    assign w_rd         = w_hit && !s_wr;
    assign w_off        = s_addr[7:0];
    assign w_busy       = (r_state != S_IDLE) || r_run;
    assign w_start_ok   = w_wr && (w_off == 8'h00) && s_din[0] && !w_busy;
    assign w_clear      = w_wr && (w_off == 8'h08) && s_din[0];
    assign w_inten_wr   = w_wr && (w_off == 8'h18);
    assign w_op_wr      = w_wr && (w_off == 8'h20);
    assign w_pop_wr     = w_wr && (w_off == 8'h38) && s_din[0];
    assign w_unused_din = ^s_din[63:OPW];

    // Queue status. A push into a full operand queue is dropped even when
    // the engine pops in the same cycle; a result push may use a same-cycle pop.
    assign w_op_empty  = (r_op_cnt == 8'd0);
    assign w_op_full   = (r_op_cnt == DEPTH_C);
    assign w_res_empty = (r_res_cnt == 8'd0);
    assign w_res_full  = (r_res_cnt == DEPTH_C);
    assign w_op_push   = w_op_wr && !w_op_full;
    assign w_op_pop    = (r_state == S_LOAD) && !w_op_empty;
    assign w_res_pop   = w_pop_wr && !w_res_empty;
    assign w_res_push  = (r_state == S_STORE) && (!w_res_full || w_res_pop);
    assign w_prod      = PRODW'(r_acc) * PRODW'(r_k);
    assign w_head_res  = w_res_empty ? '0 : r_res_mem[r_res_rptr][RES_W-1:0];
    assign w_head_flag = w_res_empty ? 1'b0 : r_res_mem[r_res_rptr][RES_W];
    assign interrupt   = r_irq;
    assign o_dbg_state = r_state;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next-state: IDLE -> LOAD -> MUL (max(n,1) cycles) -> STORE -> LOAD/IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_run && !w_op_empty) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_MUL;
            S_MUL:   if (r_k <= OPW'(1)) w_state_nxt = S_STORE;
            S_STORE: if (w_res_push) w_state_nxt = w_op_empty ? S_IDLE : S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_clear) w_state_nxt = S_IDLE;
    end

    // Engine datapath and control/status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0; r_k <= '0; r_f <= 1'b0;
            r_run <= 1'b0; r_done <= 1'b0; r_ovf <= 1'b0; r_err <= 1'b0;
            r_inten <= 1'b0; r_irq <= 1'b0;
        end else begin
            r_irq <= r_done && r_inten;
            if (w_inten_wr) r_inten <= s_din[0];
            if (w_clear) begin
                r_run <= 1'b0; r_done <= 1'b0; r_ovf <= 1'b0; r_err <= 1'b0;
            end else begin
                if (w_start_ok) begin
                    r_run  <= 1'b1;
                    r_done <= 1'b0;
                end
                if (w_op_wr && w_op_full) r_err <= 1'b1;
                case (r_state)
                    S_LOAD: begin
                        r_acc <= RES_W'(1);
                        r_k   <= r_op_mem[r_op_rptr];
                        r_f   <= 1'b0;
                    end
                    S_MUL: if (r_k > OPW'(1)) begin
                        r_acc <= w_prod[RES_W-1:0];
                        r_f   <= r_f | (|w_prod[PRODW-1:RES_W]);
                        r_k   <= r_k - OPW'(1);
                    end
                    S_STORE: if (w_res_push) begin
                        r_ovf <= r_ovf | r_f;
                        if (w_op_empty) begin
                            r_run  <= 1'b0;
                            r_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Queue storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (w_op_push)  r_op_mem[r_op_wptr]   <= s_din[OPW-1:0];
        if (w_res_push) r_res_mem[r_res_wptr] <= {r_f, r_acc};
    end

    // Queue pointers and occupancy counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_wptr <= '0; r_op_rptr <= '0; r_op_cnt <= '0;
            r_res_wptr <= '0; r_res_rptr <= '0; r_res_cnt <= '0;
        end else if (w_clear) begin
            r_op_wptr <= '0; r_op_rptr <= '0; r_op_cnt <= '0;
            r_res_wptr <= '0; r_res_rptr <= '0; r_res_cnt <= '0;
        end else begin
            if (w_op_push)  r_op_wptr  <= f_inc(r_op_wptr);
            if (w_op_pop)   r_op_rptr  <= f_inc(r_op_rptr);
            if (w_res_push) r_res_wptr <= f_inc(r_res_wptr);
            if (w_res_pop)  r_res_rptr <= f_inc(r_res_rptr);
            case ({w_op_push, w_op_pop})
                2'b10:   r_op_cnt <= r_op_cnt + 8'd1;
                2'b01:   r_op_cnt <= r_op_cnt - 8'd1;
                default: ;
            endcase
            case ({w_res_push, w_res_pop})
                2'b10:   r_res_cnt <= r_res_cnt + 8'd1;
                2'b01:   r_res_cnt <= r_res_cnt - 8'd1;
                default: ;
            endcase
        end
    end

    // Combinational read mux.
    always_comb begin
        s_dout = '0;
        if (w_rd) begin
            case (w_off)
                8'h10:   s_dout = {40'd0, r_res_cnt, r_op_cnt, 4'd0, r_err, r_ovf, r_done, w_busy};
                8'h18:   s_dout = {63'd0, r_inten};
                8'h28:   s_dout = {63'd0, w_head_flag};
                8'h30:   s_dout = 64'(w_head_res);
                default: s_dout = '0;
            endcase
        end
    end

endmodule
